// File: rtl/iq_sample_packer.sv
// ----------------------------------------------------------------------------
// iq_sample_packer
//
// Pairs independently strobed I and Q ADC samples into one {I, Q} word and
// writes it to the ADC sample FIFO one cycle after the pair completes. A
// sample that arrives first is held for up to SKEW_MAX cycles while it waits
// for its partner. The block counts written pairs and pairs dropped on FIFO
// full, and raises a sticky error when a sample is thrown away unmatched.
//
// Ports
//   clk        in   system clock, rising edge
//   arstn      in   asynchronous active-low reset
//   enable     in   packing enable; low discards held samples, blocks writes
//   clr_stats  in   pulse; clears pair_cnt, drop_cnt, skew_err
//   i_data     in   I sample, qualified by i_valid
//   i_valid    in   I sample strobe
//   q_data     in   Q sample, qualified by q_valid
//   q_valid    in   Q sample strobe
//   fifo_full  in   FIFO full flag
//   fifo_data  out  packed {I, Q}; valid while fifo_we is high
//   fifo_we    out  FIFO write enable
//   pair_cnt   out  pairs written (saturating)
//   drop_cnt   out  pairs dropped on fifo_full (saturating)
//   skew_err   out  sticky: a sample was discarded unmatched
// ----------------------------------------------------------------------------
module iq_sample_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int SKEW_MAX   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    arstn,
    input  logic                    enable,
    input  logic                    clr_stats,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   q_data,
    input  logic                    q_valid,
    input  logic                    fifo_full,
    output logic [2*DATA_WIDTH-1:0] fifo_data,
    output logic                    fifo_we,
    output logic [CNT_WIDTH-1:0]    pair_cnt,
    output logic [CNT_WIDTH-1:0]    drop_cnt,
    output logic                    skew_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HAVE_I = 2'd1,
        HAVE_Q = 2'd2
    } state_t;

    // The timer reads 0 on the first cycle after a sample is held, so the
    // last cycle a partner can still arrive is the one where it reads
    // SKEW_MAX-1; if nothing arrives then, the sample is discarded.
    localparam logic [7:0] TIMEOUT = 8'(SKEW_MAX - 1);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_i_q, hold_i_d;
    logic [DATA_WIDTH-1:0]   hold_q_q, hold_q_d;
    logic [7:0]              timer_q, timer_d;
    logic [2*DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
    logic                    fifo_we_q, fifo_we_d;
    logic [CNT_WIDTH-1:0]    pair_cnt_q, pair_cnt_d;
    logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
    logic                    skew_err_q, skew_err_d;

    logic                    complete;
    logic                    discard;
    logic [2*DATA_WIDTH-1:0] pair;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d  = state_q;
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        timer_d  = 8'd0;
        complete = 1'b0;
        discard  = 1'b0;
        pair     = {hold_i_q, hold_q_q};

        if (!enable) begin
            // Held samples are dropped silently; strobes are ignored.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid && q_valid) begin
                        complete = 1'b1;
                        pair     = {i_data, q_data};
                    end else if (i_valid) begin
                        hold_i_d = i_data;
                        state_d  = HAVE_I;
                    end else if (q_valid) begin
                        hold_q_d = q_data;
                        state_d  = HAVE_Q;
                    end
                end
                HAVE_I: begin
                    if (q_valid) begin
                        complete = 1'b1;
                        pair     = {hold_i_q, q_data};
                        if (i_valid) begin
                            // New I starts the next pair in the same cycle.
                            hold_i_d = i_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (i_valid) begin
                        discard  = 1'b1;
                        hold_i_d = i_data;
                    end else if (timer_q == TIMEOUT) begin
                        discard = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                HAVE_Q: begin
                    if (i_valid) begin
                        complete = 1'b1;
                        pair     = {i_data, hold_q_q};
                        if (q_valid) begin
                            hold_q_d = q_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (q_valid) begin
                        discard  = 1'b1;
                        hold_q_d = q_data;
                    end else if (timer_q == TIMEOUT) begin
                        discard = 1'b1;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // fifo_full is looked at only in the completing cycle.
        fifo_we_d   = complete && !fifo_full;
        fifo_data_d = fifo_we_d ? pair : fifo_data_q;

        // A clear wins over any event arriving in the same cycle.
        if (clr_stats) begin
            pair_cnt_d = '0;
            drop_cnt_d = '0;
            skew_err_d = 1'b0;
        end else begin
            pair_cnt_d = (complete && !fifo_full) ? sat_inc(pair_cnt_q) : pair_cnt_q;
            drop_cnt_d = (complete &&  fifo_full) ? sat_inc(drop_cnt_q) : drop_cnt_q;
            skew_err_d = skew_err_q | discard;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            hold_i_q    <= '0;
            hold_q_q    <= '0;
            timer_q     <= 8'd0;
            fifo_data_q <= '0;
            fifo_we_q   <= 1'b0;
            pair_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            skew_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_i_q    <= hold_i_d;
            hold_q_q    <= hold_q_d;
            timer_q     <= timer_d;
            fifo_data_q <= fifo_data_d;
            fifo_we_q   <= fifo_we_d;
            pair_cnt_q  <= pair_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            skew_err_q  <= skew_err_d;
        end
    end

    assign fifo_data = fifo_data_q;
    assign fifo_we   = fifo_we_q;
    assign pair_cnt  = pair_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign skew_err  = skew_err_q;

endmodule
